// File: rtl/row_operand_feeder.sv
// row_operand_feeder: accepts one packed operand row per handshake, pulses
// START to the row-matrix calculator, streams the row elements onto OP1
// after a fixed lead, then waits for a DONE rising edge and holds the
// captured result on a valid/ready output until the consumer takes it.
// Optional build macro: FEEDER_TIMEOUT_EN adds a DONE watchdog and the ERR port.
module row_operand_feeder #(
  parameter int OP1_COL      = 4,
  parameter int OP1_WIDTH    = 8,
  parameter int WEIGHT_COL   = 8,
  parameter int DSPOUT_WIDTH = 16,
  parameter int LEAD         = 2,
  parameter int TIMEOUT      = 255
) (
  input  logic                                 CLK,
  input  logic                                 RST,
  input  logic                                 IN_VALID,
  output logic                                 IN_READY,
  input  logic [OP1_COL*OP1_WIDTH-1:0]         IN_ROW,
  output logic                                 START,
  output logic signed [OP1_WIDTH-1:0]          OP1,
  input  logic                                 DONE,
  input  logic [DSPOUT_WIDTH*WEIGHT_COL-1:0]   OUT,
  output logic                                 RES_VALID,
  input  logic                                 RES_READY,
  output logic [DSPOUT_WIDTH*WEIGHT_COL-1:0]   RES_DATA
`ifdef FEEDER_TIMEOUT_EN
  ,
  output logic                                 ERR
`endif
);

  localparam int ROW_W = OP1_COL * OP1_WIDTH;
  localparam int RES_W = DSPOUT_WIDTH * WEIGHT_COL;
  localparam int IDX_W = (OP1_COL > 1) ? $clog2(OP1_COL) : 1;

  localparam logic [IDX_W-1:0] LAST_IDX = IDX_W'(OP1_COL - 1);
  localparam logic [IDX_W-1:0] IDX_ONE  = IDX_W'(1);
  localparam logic [3:0]       LEAD_M1  = 4'(LEAD - 1);

  typedef enum logic [2:0] {
    S_IDLE,
    S_START,
    S_LEAD,
    S_STREAM,
    S_WAIT_DONE,
    S_RESULT
  } state_t;

  state_t                   state_q, state_d;
  logic [ROW_W-1:0]         row_q, row_d;
  logic [3:0]               lead_cnt_q, lead_cnt_d;
  logic [IDX_W-1:0]         idx_q, idx_d;
  logic                     done_q;
  logic                     done_rise;
  logic                     capture;

  // Registered outputs: each is computed from the next state so that no
  // input reaches an output port without passing through a flop.
  logic                     in_ready_q;
  logic                     start_q;
  logic signed [OP1_WIDTH-1:0] op1_q, op1_d;
  logic                     res_valid_q;
  logic [RES_W-1:0]         res_data_q;

`ifdef FEEDER_TIMEOUT_EN
  localparam logic [7:0] TMO_LAST = 8'(TIMEOUT - 1);
  logic [7:0] tmo_q, tmo_d;
  logic       err_q, err_d;
`endif

  // Pick element idx out of a packed row; element i sits at [OP1_WIDTH*i +: OP1_WIDTH].
  function automatic logic signed [OP1_WIDTH-1:0] row_elem(
    input logic [ROW_W-1:0] row,
    input logic [IDX_W-1:0] idx
  );
    row_elem = row[OP1_WIDTH*int'(idx) +: OP1_WIDTH];
  endfunction

  // Only a low-to-high transition of DONE counts as completion, so a level
  // left high from an earlier row cannot complete the current one.
  assign done_rise = DONE & ~done_q;

  // Next-state and datapath-control decode for the sequencer.
  always_comb begin
    state_d    = state_q;
    row_d      = row_q;
    lead_cnt_d = lead_cnt_q;
    idx_d      = idx_q;
    capture    = 1'b0;
`ifdef FEEDER_TIMEOUT_EN
    tmo_d      = tmo_q;
    err_d      = err_q;
`endif
    case (state_q)
      S_IDLE: begin
        if (IN_VALID && in_ready_q) begin
          row_d   = IN_ROW;
          state_d = S_START;
        end
      end
      S_START: begin
        if (LEAD > 1) begin
          lead_cnt_d = 4'd1;
          state_d    = S_LEAD;
        end else begin
          idx_d   = '0;
          state_d = S_STREAM;
        end
      end
      S_LEAD: begin
        if (lead_cnt_q == LEAD_M1) begin
          idx_d   = '0;
          state_d = S_STREAM;
        end else begin
          lead_cnt_d = lead_cnt_q + 4'd1;
        end
      end
      S_STREAM: begin
        if (idx_q == LAST_IDX) begin
          state_d = S_WAIT_DONE;
`ifdef FEEDER_TIMEOUT_EN
          tmo_d   = 8'd0;
`endif
        end else begin
          idx_d = idx_q + IDX_ONE;
        end
      end
      S_WAIT_DONE: begin
        if (done_rise) begin
          capture = 1'b1;
          state_d = S_RESULT;
        end
`ifdef FEEDER_TIMEOUT_EN
        else if (tmo_q == TMO_LAST) begin
          err_d   = 1'b1;
          state_d = S_IDLE;
        end else begin
          tmo_d = tmo_q + 8'd1;
        end
`endif
      end
      S_RESULT: begin
        if (RES_READY && res_valid_q) begin
          state_d = S_IDLE;
        end
      end
      default: begin
        state_d = S_IDLE;
      end
    endcase
  end

  // Element presented on OP1 in the next cycle; zero outside STREAM.
  always_comb begin
    op1_d = '0;
    if (state_d == S_STREAM) begin
      op1_d = row_elem(row_d, idx_d);
    end
  end

  // Control state, counters and registered outputs; reset aborts at once.
  always_ff @(posedge CLK or posedge RST) begin
    if (RST) begin
      state_q     <= S_IDLE;
      lead_cnt_q  <= 4'd0;
      idx_q       <= '0;
      done_q      <= 1'b0;
      in_ready_q  <= 1'b0;
      start_q     <= 1'b0;
      op1_q       <= '0;
      res_valid_q <= 1'b0;
      res_data_q  <= '0;
    end else begin
      state_q     <= state_d;
      lead_cnt_q  <= lead_cnt_d;
      idx_q       <= idx_d;
      done_q      <= DONE;
      in_ready_q  <= (state_d == S_IDLE);
      start_q     <= (state_d == S_START);
      op1_q       <= op1_d;
      res_valid_q <= (state_d == S_RESULT);
      if (capture) begin
        res_data_q <= OUT;
      end
    end
  end

  // Row holding register: pure data, rewritten only at the input handshake.
  always_ff @(posedge CLK) begin
    row_q <= row_d;
  end

`ifdef FEEDER_TIMEOUT_EN
  // DONE watchdog counter and sticky error flag.
  always_ff @(posedge CLK or posedge RST) begin
    if (RST) begin
      tmo_q <= 8'd0;
      err_q <= 1'b0;
    end else begin
      tmo_q <= tmo_d;
      err_q <= err_d;
    end
  end

  assign ERR = err_q;
`endif

  assign IN_READY  = in_ready_q;
  assign START     = start_q;
  assign OP1       = op1_q;
  assign RES_VALID = res_valid_q;
  assign RES_DATA  = res_data_q;

endmodule
